// File: rtl/serv_arb_pkg.sv
// ---------------------------------------------------------------------------
// serv_arb_pkg: state encoding and grant IDs for serv_mem_arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serv_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_IBUS = 2'd1;
   localparam logic [1:0] ST_DBUS = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      IBUS = ST_IBUS,
      DBUS = ST_DBUS
   } arb_state_t;

   localparam logic GNT_IBUS = 1'b0;
   localparam logic GNT_DBUS = 1'b1;

   // Winner of a simultaneous request: alternate with last grant, or dbus fixed.
   function automatic logic tie_winner(input logic round_robin, input logic last_grant);
      return round_robin ? ~last_grant : GNT_DBUS;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serv_arb_timer.sv
// ---------------------------------------------------------------------------
// serv_arb_timer: saturating busy-cycle counter with timeout compare. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serv_arb_timer #(
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   generate
      if (TIMEOUT > 0) begin : g_timer
         logic [TW-1:0] cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= '0;
            end else if (clr) begin
               cnt <= '0;
            end else if (en && (cnt != '1)) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign expire = (cnt == TW'(TIMEOUT - 1));
      end else begin : g_no_timer
         logic unused_inputs;
         assign unused_inputs = &{1'b0, clk, rst_n, clr, en};
         assign expire        = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/serv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// serv_mem_arbiter: shares one Wishbone port between ibus and dbus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serv_mem_arbiter
   import serv_arb_pkg::*;
#(
   parameter int ROUND_ROBIN = 1,
   parameter int TIMEOUT     = 255,
   parameter int TW          = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   output logic        o_ibus_err,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   output logic        o_dbus_err,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack,
   output logic        o_busy
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       last_grant;
   logic       last_grant_nxt;
   logic       grant_cyc;
   logic       grant_ack;
   logic       expire;
   logic       timeout_err;
   logic       winner;

   always_comb begin
      grant_cyc = 1'b0;
      case (state)
         IBUS:    grant_cyc = i_ibus_cyc;
         DBUS:    grant_cyc = i_dbus_cyc;
         default: grant_cyc = 1'b0;
      endcase
   end

   assign grant_ack   = i_wb_ack & grant_cyc;
   // Ack beats a coincident timeout.
   assign timeout_err = expire & grant_cyc & ~i_wb_ack;

   serv_arb_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_timer (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .clr    (state == IDLE),
      .en     (grant_cyc & ~i_wb_ack),
      .expire (expire)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         last_grant <= GNT_DBUS;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      winner         = tie_winner(ROUND_ROBIN != 0, last_grant);
      case (state)
         IDLE: begin
            if (i_ibus_cyc && i_dbus_cyc) begin
               state_nxt      = (winner == GNT_DBUS) ? DBUS : IBUS;
               last_grant_nxt = winner;
            end else if (i_ibus_cyc) begin
               state_nxt      = IBUS;
               last_grant_nxt = GNT_IBUS;
            end else if (i_dbus_cyc) begin
               state_nxt      = DBUS;
               last_grant_nxt = GNT_DBUS;
            end
         end
         IBUS, DBUS: begin
            if (!grant_cyc || grant_ack || timeout_err) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      if (state == IBUS) begin
         o_wb_adr = i_ibus_adr;
         o_wb_dat = 32'h0;
         o_wb_sel = 4'hf;
         o_wb_we  = 1'b0;
      end else begin
         o_wb_adr = i_dbus_adr;
         o_wb_dat = i_dbus_dat;
         o_wb_sel = i_dbus_sel;
         o_wb_we  = i_dbus_we;
      end
   end

   assign o_wb_cyc   = grant_cyc;
   assign o_busy     = (state != IDLE);
   assign o_ibus_ack = grant_ack & (state == IBUS);
   assign o_dbus_ack = grant_ack & (state == DBUS);
   assign o_ibus_err = timeout_err & (state == IBUS);
   assign o_dbus_err = timeout_err & (state == DBUS);
   assign o_ibus_rdt = i_wb_rdt;
   assign o_dbus_rdt = i_wb_rdt;

endmodule

`default_nettype wire

// File: tb/tb_serv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serv_mem_arbiter: two arbiter configurations against a transaction model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [31:0] iadr [2];
   logic [31:0] dadr [2];
   logic [31:0] ddat [2];
   logic [31:0] wrdt [2];
   logic [3:0]  dsel [2];
   logic        dwe  [2];
   logic        icyc [2];
   logic        dcyc [2];
   logic        wack [2];

   logic [31:0] irdt [2];
   logic [31:0] drdt [2];
   logic [31:0] wadr [2];
   logic [31:0] wdat [2];
   logic [3:0]  wsel [2];
   logic        iack [2];
   logic        ierr [2];
   logic        dack [2];
   logic        derr [2];
   logic        wwe  [2];
   logic        wcyc [2];
   logic        busy [2];

   int vectors    = 0;
   int miscompares = 0;

   // Model: owner 0=none 1=ibus 2=dbus, last owner, busy cycles of current grant (1-based)
   int   mst   [2];
   int   mlast [2];
   int   nb    [2];
   logic e_iack [2];
   logic e_ierr [2];
   logic e_dack [2];
   logic e_derr [2];

   typedef struct {
      logic       i;
      logic       d;
      logic       a;
      logic [5:0] exp;   // {cyc, busy, ibus_ack, ibus_err, dbus_ack, dbus_err}
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   serv_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4), .TW(3)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ibus_adr(iadr[0]), .i_ibus_cyc(icyc[0]),
      .o_ibus_rdt(irdt[0]), .o_ibus_ack(iack[0]), .o_ibus_err(ierr[0]),
      .i_dbus_adr(dadr[0]), .i_dbus_dat(ddat[0]), .i_dbus_sel(dsel[0]),
      .i_dbus_we(dwe[0]), .i_dbus_cyc(dcyc[0]),
      .o_dbus_rdt(drdt[0]), .o_dbus_ack(dack[0]), .o_dbus_err(derr[0]),
      .o_wb_adr(wadr[0]), .o_wb_dat(wdat[0]), .o_wb_sel(wsel[0]), .o_wb_we(wwe[0]),
      .o_wb_cyc(wcyc[0]), .i_wb_rdt(wrdt[0]), .i_wb_ack(wack[0]), .o_busy(busy[0])
   );

   serv_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0), .TW(8)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ibus_adr(iadr[1]), .i_ibus_cyc(icyc[1]),
      .o_ibus_rdt(irdt[1]), .o_ibus_ack(iack[1]), .o_ibus_err(ierr[1]),
      .i_dbus_adr(dadr[1]), .i_dbus_dat(ddat[1]), .i_dbus_sel(dsel[1]),
      .i_dbus_we(dwe[1]), .i_dbus_cyc(dcyc[1]),
      .o_dbus_rdt(drdt[1]), .o_dbus_ack(dack[1]), .o_dbus_err(derr[1]),
      .o_wb_adr(wadr[1]), .o_wb_dat(wdat[1]), .o_wb_sel(wsel[1]), .o_wb_we(wwe[1]),
      .o_wb_cyc(wcyc[1]), .i_wb_rdt(wrdt[1]), .i_wb_ack(wack[1]), .o_busy(busy[1])
   );

   function automatic int cfg_rr(int k);
      return (k == 0) ? 1 : 0;
   endfunction

   function automatic int cfg_to(int k);
      return (k == 0) ? 4 : 0;
   endfunction

   task automatic expect_val(string name, logic [63:0] got, logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mst[k]    = 0;
         mlast[k]  = 2;
         nb[k]     = 0;
         e_iack[k] = 1'b0;
         e_ierr[k] = 1'b0;
         e_dack[k] = 1'b0;
         e_derr[k] = 1'b0;
      end
   endtask

   task automatic set_in(logic i, logic d, logic a);
      for (int k = 0; k < 2; k++) begin
         icyc[k] = i;
         dcyc[k] = d;
         wack[k] = a;
      end
   endtask

   task automatic set_rdt(logic [31:0] v);
      for (int k = 0; k < 2; k++) wrdt[k] = v;
   endtask

   // Called at posedge+1 with inputs set; checks both DUTs, returns at next posedge+1.
   task automatic step();
      int   nst   [2];
      int   nlast [2];
      int   nnb   [2];
      int   win;
      logic gc, ak, er, bad;
      #2;
      for (int k = 0; k < 2; k++) begin
         gc = (mst[k] == 1) ? icyc[k] : (mst[k] == 2) ? dcyc[k] : 1'b0;
         ak = wack[k] & gc;
         er = (cfg_to(k) != 0) && gc && !ak && (nb[k] == cfg_to(k));
         e_iack[k] = ak && (mst[k] == 1);
         e_ierr[k] = er && (mst[k] == 1);
         e_dack[k] = ak && (mst[k] == 2);
         e_derr[k] = er && (mst[k] == 2);
         bad = 1'b0;
         vectors++;
         if ({wcyc[k], busy[k], iack[k], ierr[k], dack[k], derr[k]} !==
             {gc, (mst[k] != 0), e_iack[k], e_ierr[k], e_dack[k], e_derr[k]}) begin
            $display("FAIL ctrl dut%0d at %0t: got %b want %b", k, $time,
                     {wcyc[k], busy[k], iack[k], ierr[k], dack[k], derr[k]},
                     {gc, (mst[k] != 0), e_iack[k], e_ierr[k], e_dack[k], e_derr[k]});
            bad = 1'b1;
         end
         if (irdt[k] !== wrdt[k] || drdt[k] !== wrdt[k]) begin
            $display("FAIL rdt dut%0d at %0t: got %h/%h want %h", k, $time, irdt[k], drdt[k], wrdt[k]);
            bad = 1'b1;
         end
         if (mst[k] == 1 && {wadr[k], wsel[k], wwe[k]} !== {iadr[k], 4'hf, 1'b0}) begin
            $display("FAIL ibus_mux dut%0d at %0t: got %h %h %b want %h f 0", k, $time,
                     wadr[k], wsel[k], wwe[k], iadr[k]);
            bad = 1'b1;
         end
         if (mst[k] == 2 && {wadr[k], wdat[k], wsel[k], wwe[k]} !== {dadr[k], ddat[k], dsel[k], dwe[k]}) begin
            $display("FAIL dbus_mux dut%0d at %0t: got %h %h %h %b want %h %h %h %b", k, $time,
                     wadr[k], wdat[k], wsel[k], wwe[k], dadr[k], ddat[k], dsel[k], dwe[k]);
            bad = 1'b1;
         end
         if (bad) miscompares++;

         nlast[k] = mlast[k];
         if (mst[k] == 0) begin
            win = 0;
            if (icyc[k] && dcyc[k]) win = (cfg_rr(k) != 0) ? ((mlast[k] == 2) ? 1 : 2) : 2;
            else if (icyc[k])       win = 1;
            else if (dcyc[k])       win = 2;
            nst[k] = win;
            if (win != 0) nlast[k] = win;
            nnb[k] = 1;
         end else begin
            nst[k] = (!gc || ak || er) ? 0 : mst[k];
            nnb[k] = nb[k] + 1;
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         mst[k]   = nst[k];
         mlast[k] = nlast[k];
         nb[k]    = nnb[k];
      end
      #1;
   endtask

   // Asynchronous reset asserted wherever the caller is in the cycle.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         expect_val($sformatf("reset_outputs dut%0d", k),
                    {58'd0, wcyc[k], busy[k], iack[k], ierr[k], dack[k], derr[k]}, 64'd0);
      end
      set_in(1'b0, 1'b0, 1'b0);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic ipend [2];
   logic dpend [2];

   initial begin
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         iadr[k] = 32'h100; dadr[k] = 32'h0; ddat[k] = 32'h0; dsel[k] = 4'h0;
         dwe[k] = 1'b0; wrdt[k] = 32'h0;
      end
      set_in(1'b0, 1'b0, 1'b0);
      #1;
      do_reset();

      // Tie alternation, ignored acks in IDLE and ibus timeout
      tbl[0] = '{1'b1, 1'b1, 1'b0, 6'b000000};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 6'b111000};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 6'b000000};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 6'b110010};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 6'b000000};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 6'b110000};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 6'b110000};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 6'b110000};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 6'b110100};
      tbl[9] = '{1'b0, 1'b0, 1'b1, 6'b000000};
      for (int r = 0; r < 10; r++) begin
         set_in(tbl[r].i, tbl[r].d, tbl[r].a);
         #1;
         expect_val($sformatf("table row %0d", r),
                    {58'd0, wcyc[0], busy[0], iack[0], ierr[0], dack[0], derr[0]},
                    {58'd0, tbl[r].exp});
         step();
      end

      // ibus read, ack on third busy cycle
      for (int k = 0; k < 2; k++) iadr[k] = 32'h100;
      set_in(1'b1, 1'b0, 1'b0);
      step();
      #1 expect_val("ibus grant latency", {63'd0, wcyc[0]}, 64'd1);
      step();
      step();
      set_in(1'b1, 1'b0, 1'b1);
      set_rdt(32'h00000013);
      #1;
      expect_val("ibus ack", {63'd0, iack[0]}, 64'd1);
      expect_val("ibus rdt", {32'd0, irdt[0]}, 64'h13);
      expect_val("ibus sel/adr", {28'd0, wsel[0], wadr[0]}, {28'd0, 4'hf, 32'h100});
      step();
      set_in(1'b0, 1'b0, 1'b0);
      step();

      // dbus write
      for (int k = 0; k < 2; k++) begin
         dadr[k] = 32'h2000; ddat[k] = 32'hdeadbeef; dsel[k] = 4'b0011; dwe[k] = 1'b1;
      end
      set_in(1'b0, 1'b1, 1'b0);
      step();
      set_in(1'b0, 1'b1, 1'b1);
      #1;
      expect_val("dbus write bus", {wadr[0], wdat[0]}, {32'h2000, 32'hdeadbeef});
      expect_val("dbus write sel/we/ack", {58'd0, wsel[0], wwe[0], dack[0]}, {58'd0, 4'b0011, 1'b1, 1'b1});
      step();
      set_in(1'b0, 1'b0, 1'b0);
      step();

      // dbus timeout, then ack on the timeout cycle
      set_in(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) step();
      #1 expect_val("dbus timeout err/ack", {62'd0, derr[0], dack[0]}, 64'b10);
      step();
      set_in(1'b0, 1'b0, 1'b0);
      step();
      set_in(1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 4; c++) step();
      set_in(1'b0, 1'b1, 1'b1);
      #1 expect_val("ack beats timeout err/ack", {62'd0, derr[0], dack[0]}, 64'b01);
      step();
      set_in(1'b0, 1'b0, 1'b0);
      step();

      // ibus abort with late ack
      set_in(1'b1, 1'b0, 1'b0);
      step();
      step();
      step();
      set_in(1'b0, 1'b0, 1'b1);
      #1 expect_val("abort cyc/ack", {62'd0, wcyc[0], iack[0]}, 64'd0);
      step();
      set_in(1'b0, 1'b0, 1'b0);
      #1 expect_val("abort idle", {63'd0, busy[0]}, 64'd0);
      step();

      // reset mid ibus transaction
      set_in(1'b1, 1'b0, 1'b0);
      step();
      step();
      #2;
      do_reset();

      // Randomized traffic on both configurations
      for (int k = 0; k < 2; k++) begin
         ipend[k] = 1'b0;
         dpend[k] = 1'b0;
      end
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            for (int k = 0; k < 2; k++) begin
               ipend[k] = 1'b0;
               dpend[k] = 1'b0;
            end
            #2;
            do_reset();
         end
         for (int k = 0; k < 2; k++) begin
            if (ipend[k] && (e_iack[k] || e_ierr[k]))  ipend[k] = 1'b0;
            else if (ipend[k] && $urandom_range(0, 31) == 0) ipend[k] = 1'b0;
            if (!ipend[k] && $urandom_range(0, 2) == 0) begin
               ipend[k] = 1'b1;
               iadr[k]  = $urandom & 32'hffff_fffc;
            end
            if (dpend[k] && (e_dack[k] || e_derr[k]))  dpend[k] = 1'b0;
            else if (dpend[k] && $urandom_range(0, 31) == 0) dpend[k] = 1'b0;
            if (!dpend[k] && $urandom_range(0, 2) == 0) begin
               dpend[k] = 1'b1;
               dadr[k]  = $urandom;
               ddat[k]  = $urandom;
               dsel[k]  = 4'($urandom_range(0, 15));
               dwe[k]   = 1'($urandom_range(0, 1));
            end
            icyc[k] = ipend[k];
            dcyc[k] = dpend[k];
            wack[k] = ($urandom_range(0, 2) == 0);
            wrdt[k] = $urandom;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
